// File: rtl/opf_pkg.sv
// ============================================================================
// Module   : opf_pkg
// Brief    : Shared types and default widths for the operand-fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package opf_pkg;

  localparam int OPF_DATA_WIDTH = 16;
  localparam int OPF_REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    DONE   = 2'd3
  } opf_state_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_op_t;

endpackage : opf_pkg

`default_nettype wire

// File: rtl/opf_shifter.sv
// ============================================================================
// Module   : opf_shifter
// Brief    : Combinational single-bit shifter applied to the B operand.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module opf_shifter
  import opf_pkg::*;
#(
  parameter int DATA_WIDTH = OPF_DATA_WIDTH
) (
  input  shift_op_t             op,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    case (op)
      SH_NONE: dout = din;
      SH_LSL1: dout = {din[DATA_WIDTH-2:0], 1'b0};
      SH_LSR1: dout = {1'b0, din[DATA_WIDTH-1:1]};
      SH_ASR1: dout = {din[DATA_WIDTH-1], din[DATA_WIDTH-1:1]};
      default: dout = din;
    endcase
  end

endmodule : opf_shifter

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module   : operand_fetch
// Brief    : Multicycle Rn/Rm fetch through one regfile read port, shifts B,
//            hands A/B to the ALU via valid/ready. Optional writeback bypass
//            enabled by defining OPF_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch
  import opf_pkg::*;
#(
  parameter int DATA_WIDTH = OPF_DATA_WIDTH,
  parameter int REG_ADDR_W = OPF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rn,
  input  logic [REG_ADDR_W-1:0] rm,
  input  logic                  need_a,
  input  logic                  need_b,
  input  logic [1:0]            shift,
  output logic [REG_ADDR_W-1:0] readnum,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  wb_write,
  input  logic [REG_ADDR_W-1:0] wb_writenum,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out
);

  opf_state_t            r_state;
  opf_state_t            w_next_state;
  logic [REG_ADDR_W-1:0] r_rm;
  logic                  r_need_b;
  shift_op_t             r_shift;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [REG_ADDR_W-1:0] r_readnum;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] w_b_shifted;

`ifdef OPF_WB_BYPASS_EN
  // The regfile updates on the same edge we sample, so forward the write.
  assign w_rd_data = (wb_write && (wb_writenum == r_readnum)) ? wb_data : rf_data;
`else
  logic w_unused_wb;
  assign w_unused_wb = wb_write ^ (^wb_writenum) ^ (^wb_data);
  assign w_rd_data   = rf_data;
`endif

  opf_shifter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shifter (
    .op  (r_shift),
    .din (w_rd_data),
    .dout(w_b_shifted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (need_a)      w_next_state = READ_A;
          else if (need_b) w_next_state = READ_B;
          else             w_next_state = DONE;
        end
      end
      READ_A:  w_next_state = r_need_b ? READ_B : DONE;
      READ_B:  w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // readnum is registered and pre-loaded one state ahead so it stays glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rm      <= '0;
      r_need_b  <= 1'b0;
      r_shift   <= SH_NONE;
      r_a       <= '0;
      r_b       <= '0;
      r_readnum <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_rm     <= rm;
            r_need_b <= need_b;
            r_shift  <= shift_op_t'(shift);
            r_a      <= '0;
            r_b      <= '0;
            if (need_a)      r_readnum <= rn;
            else if (need_b) r_readnum <= rm;
          end
        end
        READ_A: begin
          r_a <= w_rd_data;
          if (r_need_b) r_readnum <= r_rm;
        end
        READ_B: r_b <= w_b_shifted;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign a_out     = r_a;
  assign b_out     = r_b;
  assign readnum   = r_readnum;

endmodule : operand_fetch

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module   : tb_operand_fetch
// Brief    : Directed plus randomized checks of operand_fetch against a
//            transaction-level model (register array, latency = 1+na+nb).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  rn, rm;
  logic        need_a, need_b;
  logic [1:0]  shift;
  logic [2:0]  readnum;
  logic [15:0] rf_data;
  logic        wb_write;
  logic [2:0]  wb_writenum;
  logic [15:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] a_out, b_out;

  logic [15:0] regs [8];
  logic [15:0] m_regs [8];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rn         (rn),
    .rm         (rm),
    .need_a     (need_a),
    .need_b     (need_b),
    .shift      (shift),
    .readnum    (readnum),
    .rf_data    (rf_data),
    .wb_write   (wb_write),
    .wb_writenum(wb_writenum),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_out      (a_out),
    .b_out      (b_out)
  );

  // Regfile: combinational read, write on the clock edge.
  assign rf_data = regs[readnum];
  always @(posedge clk) if (wb_write) regs[wb_writenum] <= wb_data;

  function automatic logic [15:0] shref(input logic [1:0] op, input logic [15:0] v);
    int x;
    x = int'(v);
    case (op)
      2'b01:   return 16'((x * 2) % 65536);
      2'b10:   return 16'(x / 2);
      2'b11:   return 16'(x / 2 + ((x >= 32768) ? 32768 : 0));
      default: return v;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rf_write(input int idx, input logic [15:0] val);
    wb_write = 1'b1; wb_writenum = 3'(idx); wb_data = val;
    @(posedge clk); #1;
    wb_write = 1'b0;
    m_regs[idx] = val;
  endtask

  // One full transaction; collide drives a same-register write during READ_A.
  task automatic do_req(input int rn_i, input int rm_i, input bit na, input bit nb,
                        input logic [1:0] sh, input int hold, input bit collide,
                        input logic [15:0] cdata);
    logic [15:0] ea, eb;
    logic [2:0]  rd_q [$];
    logic [2:0]  exp_q [$];
    int lat, cnt;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; rn = 3'(rn_i); rm = 3'(rm_i); need_a = na; need_b = nb; shift = sh;
    @(posedge clk); #1;
    in_valid = 1'b0; rn = 3'($urandom); rm = 3'($urandom);
    need_a = 1'($urandom); need_b = 1'($urandom); shift = 2'($urandom);
    lat = 1 + int'(na) + int'(nb);
    ea  = na ? m_regs[rn_i] : 16'h0;
    eb  = nb ? shref(sh, m_regs[rm_i]) : 16'h0;
    if (collide && na) begin
      wb_write = 1'b1; wb_writenum = 3'(rn_i); wb_data = cdata;
`ifdef OPF_WB_BYPASS_EN
      ea = cdata;
`endif
      m_regs[rn_i] = cdata;
    end
    cnt = 1;
    while (!out_valid && cnt < 8) begin
      rd_q.push_back(readnum);
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      wb_write = 1'b0;
      cnt++;
    end
    wb_write = 1'b0;
    chk("latency", 32'(cnt), 32'(lat));
    if (na) exp_q.push_back(3'(rn_i));
    if (nb) exp_q.push_back(3'(rm_i));
    chk("readnum_count", 32'(rd_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++)
      chk("readnum_seq", 32'(rd_q[i]), 32'(exp_q[i]));
    if (exp_q.size() > 0) chk("readnum_hold", 32'(readnum), 32'(exp_q[exp_q.size()-1]));
    for (int h = 0; h <= hold; h++) begin
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("a_out", 32'(a_out), 32'(ea));
      chk("b_out", 32'(b_out), 32'(eb));
      chk("in_ready_done", 32'(in_ready), 32'd0);
      if (h < hold) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int r1, r2;
    reset = 1'b1; in_valid = 1'b0; rn = '0; rm = '0; need_a = 1'b0; need_b = 1'b0;
    shift = '0; wb_write = 1'b0; wb_writenum = '0; wb_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_a_out", 32'(a_out), 32'd0);
    chk("rst_b_out", 32'(b_out), 32'd0);
    chk("rst_readnum", 32'(readnum), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) rf_write(i, 16'($urandom));

    // Both operands, no shift
    rf_write(2, 16'd42);
    rf_write(5, 16'd7);
    do_req(2, 5, 1, 1, 2'b00, 0, 0, 16'h0);

    // B-only with each shift
    rf_write(3, 16'h8004);
    do_req(0, 3, 0, 1, 2'b11, 0, 0, 16'h0);
    do_req(0, 3, 0, 1, 2'b01, 0, 0, 16'h0);
    do_req(0, 3, 0, 1, 2'b10, 0, 0, 16'h0);

    // Backpressure for four cycles, and rn==rm
    do_req(5, 5, 1, 1, 2'b11, 4, 0, 16'h0);

    // Reset during READ_B
    in_valid = 1'b1; rn = 3'd2; rm = 3'd5; need_a = 1'b1; need_b = 1'b1; shift = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_a_out", 32'(a_out), 32'd0);
    chk("midrst_b_out", 32'(b_out), 32'd0);
    chk("midrst_readnum", 32'(readnum), 32'd0);
    do_req(2, 5, 1, 1, 2'b01, 1, 0, 16'h0);

    // Write collision on the A read
    rf_write(4, 16'd10);
    do_req(4, 0, 1, 0, 2'b00, 0, 1, 16'd99);

    // No operands
    do_req(1, 6, 0, 0, 2'b11, 1, 0, 16'h0);

    // Randomized transactions
    for (int it = 0; it < 40; it++) begin
      r1 = int'($urandom_range(0, 7));
      r2 = (it % 5 == 0) ? r1 : int'($urandom_range(0, 7));
      rf_write(r1, 16'($urandom));
      rf_write(r2, 16'($urandom));
      do_req(r1, r2, 1'($urandom), 1'($urandom), 2'($urandom),
             int'($urandom_range(0, 3)), 0, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_operand_fetch

`default_nettype wire
